// File: rtl/mem_responder_pkg.sv
// Shared types for the instruction-memory read responder: FSM state encoding
// and the helper that sizes the read-latency countdown.
package mem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int DEFAULT_READ_LATENCY = 1;

    // The countdown starts at latency-1 and stops at zero, so it never wraps.
    function automatic int lat_cnt_width(input int latency);
        return (latency < 1) ? 1 : $clog2(latency + 1);
    endfunction

endpackage

// File: rtl/ram_sp_sync.sv
// Single-port synchronous RAM: registered read into an output register chain
// whose length equals LATENCY, so read data appears LATENCY cycles after the address edge.
module ram_sp_sync #(
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 11,
    parameter int LATENCY    = 1
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WIDTH-1:0]      wdata,
    output logic [WIDTH-1:0]      rdata
);

    logic [WIDTH-1:0] mem  [0:(1 << ADDR_WIDTH) - 1];
    logic [WIDTH-1:0] pipe [0:LATENCY-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            pipe[0] <= mem[addr];
        end
        for (int i = 1; i < LATENCY; i++) begin
            pipe[i] <= pipe[i-1];
        end
    end

    assign rdata = pipe[LATENCY-1];

endmodule

// File: rtl/memory_read_responder.sv
// Instruction-memory read responder: serves arbitrated engine reads, broadcasts each
// returned word, and accepts program-load writes while idle. Optional last-read
// bypass register is enabled with the CICERO_MEM_HIT_BYPASS_EN macro.
module memory_read_responder
    import mem_responder_pkg::*;
#(
    parameter int MEMORY_WIDTH      = 16,
    parameter int MEMORY_ADDR_WIDTH = 11,
    parameter int READ_LATENCY      = DEFAULT_READ_LATENCY
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         mem_valid,
    input  logic [MEMORY_ADDR_WIDTH-1:0] mem_addr,
    output logic                         mem_ready,
    output logic [MEMORY_WIDTH-1:0]      mem_data,
    output logic                         broadcast_valid,
    output logic [MEMORY_ADDR_WIDTH-1:0] broadcast_addr,
    input  logic                         load_valid,
    input  logic [MEMORY_ADDR_WIDTH-1:0] load_addr,
    input  logic [MEMORY_WIDTH-1:0]      load_data,
    output logic                         load_ready,
    output logic                         busy
);

    localparam int CNT_W = lat_cnt_width(READ_LATENCY);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(READ_LATENCY - 1);

    state_t                         state, next_state;
    logic [CNT_W-1:0]               cnt, cnt_next;
    logic [MEMORY_ADDR_WIDTH-1:0]   addr_q, addr_next;
    logic                           ram_we, ram_re;
    logic [MEMORY_ADDR_WIDTH-1:0]   ram_addr;
    logic [MEMORY_WIDTH-1:0]        ram_q;
    logic                           resp_from_ram, resp_from_hit;
    logic                           hit;
    logic [MEMORY_WIDTH-1:0]        hit_word;

    ram_sp_sync #(
        .WIDTH      (MEMORY_WIDTH),
        .ADDR_WIDTH (MEMORY_ADDR_WIDTH),
        .LATENCY    (READ_LATENCY)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (load_data),
        .rdata (ram_q)
    );

`ifdef CICERO_MEM_HIT_BYPASS_EN
    logic                         hit_valid;
    logic [MEMORY_ADDR_WIDTH-1:0] hit_addr;
    logic [MEMORY_WIDTH-1:0]      hit_data;

    assign hit      = hit_valid && (hit_addr == mem_addr);
    assign hit_word = hit_data;

    // Remember the last RAM-served word; any program load may overwrite it, so drop it.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_valid <= 1'b0;
            hit_addr  <= '0;
            hit_data  <= '0;
        end else if (ram_we) begin
            hit_valid <= 1'b0;
        end else if (resp_from_ram) begin
            hit_valid <= 1'b1;
            hit_addr  <= addr_q;
            hit_data  <= ram_q;
        end
    end
`else
    assign hit      = 1'b0;
    assign hit_word = '0;
`endif

    // Reads take priority over loads in IDLE; a load only writes when no read is presented.
    always_comb begin
        next_state    = state;
        cnt_next      = cnt;
        addr_next     = addr_q;
        ram_we        = 1'b0;
        ram_re        = 1'b0;
        ram_addr      = mem_addr;
        load_ready    = 1'b0;
        resp_from_ram = 1'b0;
        resp_from_hit = 1'b0;
        case (state)
            IDLE: begin
                if (mem_valid) begin
                    addr_next = mem_addr;
                    if (hit) begin
                        resp_from_hit = 1'b1;
                        next_state    = RESP;
                    end else begin
                        ram_re     = 1'b1;
                        cnt_next   = CNT_INIT;
                        next_state = READ;
                    end
                end else if (load_valid) begin
                    ram_addr   = load_addr;
                    ram_we     = 1'b1;
                    load_ready = 1'b1;
                end
            end
            READ: begin
                if (cnt == '0) begin
                    resp_from_ram = 1'b1;
                    next_state    = RESP;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            RESP: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
        if (rst) begin
            ram_we     = 1'b0;
            load_ready = 1'b0;
        end
    end

    // Response outputs are registered on the edge that enters RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            addr_q         <= '0;
            mem_ready      <= 1'b0;
            mem_data       <= '0;
            broadcast_addr <= '0;
        end else begin
            state     <= next_state;
            cnt       <= cnt_next;
            addr_q    <= addr_next;
            mem_ready <= resp_from_ram | resp_from_hit;
            if (resp_from_ram) begin
                mem_data <= ram_q;
            end else if (resp_from_hit) begin
                mem_data <= hit_word;
            end else begin
                mem_data <= '0;
            end
            broadcast_addr <= (resp_from_ram | resp_from_hit) ? addr_next : '0;
        end
    end

    assign broadcast_valid = mem_ready;
    assign busy            = (state != IDLE);

endmodule

// File: tb/tb_memory_read_responder.sv
// Scoreboard bench for memory_read_responder: one instance at READ_LATENCY=1 and one at 3;
// stimulus pushes expected responses, a negedge monitor pops them on every mem_ready.
module tb_memory_read_responder;

    localparam int W  = 16;
    localparam int AW = 11;

    typedef struct {
        logic [AW-1:0] addr;
        logic [W-1:0]  data;
        int            cycle;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst             [2];
    logic          mem_valid       [2];
    logic [AW-1:0] mem_addr        [2];
    logic          mem_ready       [2];
    logic [W-1:0]  mem_data        [2];
    logic          broadcast_valid [2];
    logic [AW-1:0] broadcast_addr  [2];
    logic          load_valid      [2];
    logic [AW-1:0] load_addr       [2];
    logic [W-1:0]  load_data       [2];
    logic          load_ready      [2];
    logic          busy            [2];

    memory_read_responder #(.MEMORY_WIDTH(W), .MEMORY_ADDR_WIDTH(AW), .READ_LATENCY(1)) dut_lat1 (
        .clk(clk), .rst(rst[0]), .mem_valid(mem_valid[0]), .mem_addr(mem_addr[0]),
        .mem_ready(mem_ready[0]), .mem_data(mem_data[0]), .broadcast_valid(broadcast_valid[0]),
        .broadcast_addr(broadcast_addr[0]), .load_valid(load_valid[0]), .load_addr(load_addr[0]),
        .load_data(load_data[0]), .load_ready(load_ready[0]), .busy(busy[0])
    );

    memory_read_responder #(.MEMORY_WIDTH(W), .MEMORY_ADDR_WIDTH(AW), .READ_LATENCY(3)) dut_lat3 (
        .clk(clk), .rst(rst[1]), .mem_valid(mem_valid[1]), .mem_addr(mem_addr[1]),
        .mem_ready(mem_ready[1]), .mem_data(mem_data[1]), .broadcast_valid(broadcast_valid[1]),
        .broadcast_addr(broadcast_addr[1]), .load_valid(load_valid[1]), .load_addr(load_addr[1]),
        .load_data(load_data[1]), .load_ready(load_ready[1]), .busy(busy[1])
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    exp_t         q0[$];
    exp_t         q1[$];
    logic [W-1:0] model_mem [2][0:(1 << AW) - 1];
    logic         prev_ready [2];
`ifdef CICERO_MEM_HIT_BYPASS_EN
    logic          hit_valid [2];
    logic [AW-1:0] hit_addr  [2];
`endif

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual %0h required %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic check_resp(input int d);
        exp_t e;
        if (rst[d]) begin
            prev_ready[d] = 1'b0;
            return;
        end
        if (mem_ready[d]) begin
            if (prev_ready[d]) begin
                checks++;
                errors++;
                $display("[TB] FAIL ready_back_to_back: dut %0d mem_ready high two cycles, required single pulse", d);
            end
            if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_ready: dut %0d mem_ready=1 at cycle %0d, required 0", d, cyc);
            end else begin
                if (d == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                checkOutput("resp_data",   mem_data[d],        e.data);
                checkOutput("resp_bvalid", broadcast_valid[d], 1);
                checkOutput("resp_baddr",  broadcast_addr[d],  e.addr);
                checkOutput("resp_cycle",  cyc,                e.cycle);
            end
        end
        prev_ready[d] = mem_ready[d];
    endtask

    always @(negedge clk) begin
        check_resp(0);
        check_resp(1);
    end

    // Issue one read on instance d, holding mem_valid until mem_ready (or dropping it early).
    task automatic applyStimulus(input int d, input logic [AW-1:0] a, input bit drop_early);
        int   lat;
        int   k;
        bit   seen;
        exp_t e;
        lat = (d == 0) ? 2 : 4;
`ifdef CICERO_MEM_HIT_BYPASS_EN
        if (hit_valid[d] && hit_addr[d] == a) lat = 1;
`endif
        e.addr  = a;
        e.data  = model_mem[d][a];
        e.cycle = cyc + lat;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
        mem_valid[d] = 1'b1;
        mem_addr[d]  = a;
        k    = 0;
        seen = 1'b0;
        do begin
            @(negedge clk);
            seen = mem_ready[d];
            @(posedge clk);
            #1;
            if (drop_early) begin
                mem_valid[d] = 1'b0;
                mem_addr[d]  = ~a;
            end
            k++;
        end while (!seen && k < 40);
        mem_valid[d] = 1'b0;
        if (!seen) begin
            checks++;
            errors++;
            $display("[TB] FAIL read_timeout: dut %0d addr %0h no mem_ready, required after %0d cycles", d, a, lat);
        end
`ifdef CICERO_MEM_HIT_BYPASS_EN
        hit_valid[d] = 1'b1;
        hit_addr[d]  = a;
`endif
    endtask

    task automatic applyLoad(input int d, input logic [AW-1:0] a, input logic [W-1:0] data);
        load_valid[d] = 1'b1;
        load_addr[d]  = a;
        load_data[d]  = data;
        @(negedge clk);
        checkOutput("load_ready", load_ready[d], 1);
        @(posedge clk);
        #1;
        load_valid[d]    = 1'b0;
        model_mem[d][a]  = data;
`ifdef CICERO_MEM_HIT_BYPASS_EN
        hit_valid[d] = 1'b0;
`endif
    endtask

    initial begin
        int   k;
        bit   seen;
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            rst[d]        = 1'b1;
            mem_valid[d]  = 1'b0;
            mem_addr[d]   = '0;
            load_valid[d] = 1'b0;
            load_addr[d]  = '0;
            load_data[d]  = '0;
            prev_ready[d] = 1'b0;
`ifdef CICERO_MEM_HIT_BYPASS_EN
            hit_valid[d] = 1'b0;
            hit_addr[d]  = '0;
`endif
        end
        repeat (3) @(posedge clk);
        #1;
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checkOutput("rst_mem_ready",  mem_ready[d],       0);
            checkOutput("rst_bvalid",     broadcast_valid[d], 0);
            checkOutput("rst_baddr",      broadcast_addr[d],  0);
            checkOutput("rst_mem_data",   mem_data[d],        0);
            checkOutput("rst_busy",       busy[d],            0);
            checkOutput("rst_load_ready", load_ready[d],      0);
        end
        @(posedge clk);
        #1;

        // Load then read, latency 1
        applyLoad(0, 11'd5, 16'hBEEF);
        applyStimulus(0, 11'd5, 1'b0);

        // Read and load together: read returns old word, load waits for the next IDLE cycle
        applyLoad(0, 11'd9, 16'h1111);
        e.addr  = 11'd9;
        e.data  = 16'h1111;
        e.cycle = cyc + 2;
        q0.push_back(e);
        mem_valid[0]  = 1'b1;
        mem_addr[0]   = 11'd9;
        load_valid[0] = 1'b1;
        load_addr[0]  = 11'd9;
        load_data[0]  = 16'h2222;
        k    = 0;
        seen = 1'b0;
        do begin
            @(negedge clk);
            seen = mem_ready[0];
            checkOutput("load_ready_blocked", load_ready[0], 0);
            @(posedge clk);
            #1;
            k++;
        end while (!seen && k < 40);
        mem_valid[0] = 1'b0;
        if (!seen) begin
            checks++;
            errors++;
            $display("[TB] FAIL read_timeout: concurrent read of 9 never returned, required at +2 cycles");
        end
        @(negedge clk);
        checkOutput("load_ready_after_read", load_ready[0], 1);
        @(posedge clk);
        #1;
        load_valid[0]     = 1'b0;
        model_mem[0][9]   = 16'h2222;
`ifdef CICERO_MEM_HIT_BYPASS_EN
        hit_valid[0] = 1'b0;
`endif
        applyStimulus(0, 11'd9, 1'b0);

        // Reset during READ: no response, RAM preserved
        applyLoad(0, 11'd12, 16'h0C0C);
        mem_valid[0] = 1'b1;
        mem_addr[0]  = 11'd5;
        @(posedge clk);
        #1;
        mem_valid[0] = 1'b0;
        rst[0]       = 1'b1;
        @(posedge clk);
        #1;
        rst[0] = 1'b0;
`ifdef CICERO_MEM_HIT_BYPASS_EN
        hit_valid[0] = 1'b0;
`endif
        @(negedge clk);
        checkOutput("rst_mid_busy",  busy[0],      0);
        checkOutput("rst_mid_ready", mem_ready[0], 0);
        @(posedge clk);
        #1;
        applyStimulus(0, 11'd5, 1'b0);

        // Requester drops mem_valid right after acceptance
        applyStimulus(0, 11'd12, 1'b1);

        // Latency 3, back-to-back reads
        applyLoad(1, 11'd1, 16'h0101);
        applyLoad(1, 11'd2, 16'h0202);
        applyStimulus(1, 11'd1, 1'b0);
        applyStimulus(1, 11'd2, 1'b0);

`ifdef CICERO_MEM_HIT_BYPASS_EN
        applyLoad(0, 11'd7, 16'h7777);
        applyStimulus(0, 11'd7, 1'b0);
        applyStimulus(0, 11'd7, 1'b0);
        applyLoad(0, 11'd3, 16'h0303);
        applyStimulus(0, 11'd7, 1'b0);
`endif

        repeat (6) @(posedge clk);
        @(negedge clk);
        checkOutput("q0_drained", q0.size(), 0);
        checkOutput("q1_drained", q1.size(), 0);
        checkOutput("final_busy0", busy[0], 0);
        checkOutput("final_busy1", busy[1], 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
